// File: rtl/serial_deframer.sv
// Asynchronous-serial frame receiver: deframes start/data/parity/stop bits from
// the DPLL strobe stream and queues words with error flags in an FWFT FIFO.
module serial_deframer #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 clr_i,
    input  logic                 stb_i,
    input  logic                 dat_i,
    input  logic                 lock_i,
    output logic [DATA_BITS-1:0] dat_o,
    output logic                 perr_o,
    output logic                 ferr_o,
    output logic                 vld_o,
    input  logic                 rdy_i,
    output logic                 ovr_o,
    output logic                 busy_o
);

    localparam int         AW        = $clog2(FIFO_DEPTH);
    localparam int         EW        = DATA_BITS + 2;
    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_PAR,
        S_STOP,
        S_HUNT
    } state_t;

    state_t               state;
    logic [3:0]           cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 perr_r;
    logic                 ferr_r;
    logic                 busy_r;

    logic [EW-1:0]        mem [FIFO_DEPTH];
    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic                 ovr_r;

    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic                 wr_en;
    logic                 par_exp;
    logic [EW-1:0]        push_word;
    logic [EW-1:0]        head;

    always_comb begin
        par_exp   = (PARITY == 1) ? ~^shreg : ^shreg;
        push      = lock_i & stb_i & (state == S_STOP) & (cnt == LAST_STOP);
        // the last stop sample is folded in directly so the push lands on its own edge
        push_word = {perr_r, ferr_r | ~dat_i, shreg};
        empty     = (wr_ptr == rd_ptr);
        full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        pop       = ~empty & rdy_i;
        wr_en     = push & (~full | pop) & ~clr_i;
        head      = mem[rd_ptr[AW-1:0]];
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state  <= S_IDLE;
            cnt    <= '0;
            shreg  <= '0;
            perr_r <= 1'b0;
            ferr_r <= 1'b0;
            busy_r <= 1'b0;
        end else if (clr_i) begin
            state  <= S_IDLE;
            cnt    <= '0;
            shreg  <= '0;
            perr_r <= 1'b0;
            ferr_r <= 1'b0;
            busy_r <= 1'b0;
        end else if (!lock_i) begin
            state  <= S_IDLE;
            busy_r <= 1'b0;
        end else if (stb_i) begin
            case (state)
                S_IDLE: begin
                    if (!dat_i) begin
                        state  <= S_DATA;
                        cnt    <= '0;
                        perr_r <= 1'b0;
                        ferr_r <= 1'b0;
                        busy_r <= 1'b1;
                    end
                end
                S_DATA: begin
                    shreg <= {dat_i, shreg[DATA_BITS-1:1]};
                    if (cnt == LAST_DATA) begin
                        cnt   <= '0;
                        state <= (PARITY != 0) ? S_PAR : S_STOP;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                S_PAR: begin
                    perr_r <= (dat_i != par_exp);
                    state  <= S_STOP;
                end
                S_STOP: begin
                    if (!dat_i) begin
                        ferr_r <= 1'b1;
                    end
                    if (cnt == LAST_STOP) begin
                        cnt    <= '0;
                        state  <= (ferr_r | ~dat_i) ? S_HUNT : S_IDLE;
                        busy_r <= ferr_r | ~dat_i;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                S_HUNT: begin
                    if (dat_i) begin
                        state  <= S_IDLE;
                        busy_r <= 1'b0;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovr_r  <= 1'b0;
        end else if (clr_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovr_r  <= 1'b0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push) begin
                if (~full | pop) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end else begin
                    ovr_r <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= push_word;
        end
    end

    // storage is not reset, so the head fields are masked while empty
    assign vld_o  = ~empty;
    assign dat_o  = vld_o ? head[DATA_BITS-1:0] : '0;
    assign ferr_o = vld_o & head[DATA_BITS];
    assign perr_o = vld_o & head[DATA_BITS+1];
    assign ovr_o  = ovr_r;
    assign busy_o = busy_r;

endmodule

// File: tb/tb_serial_deframer.sv
// Bench for serial_deframer: an 8N1 and an 8E1 instance, a frame-level FIFO
// model checked every cycle, plus directed literal expectations.
`timescale 1ns/1ps
module tb_serial_deframer;

    typedef struct packed {
        logic [7:0] w;
        logic       pe;
        logic       fe;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst_n, clr, dat, lock;
    logic       stb_a, stb_b, rdy_a, rdy_b;
    logic [7:0] dat_a, dat_b;
    logic       perr_a, perr_b, ferr_a, ferr_b, vld_a, vld_b;
    logic       ovr_a, ovr_b, busy_a, busy_b;

    int checks = 0;
    int errors = 0;

    ent_t qa[$];
    ent_t qb[$];
    logic ovr_ma, ovr_mb;
    logic push_a = 1'b0, push_b = 1'b0;
    ent_t pw_a, pw_b;

    always #5 clk = ~clk;

    serial_deframer #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
        .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr), .stb_i(stb_a), .dat_i(dat),
        .lock_i(lock), .dat_o(dat_a), .perr_o(perr_a), .ferr_o(ferr_a),
        .vld_o(vld_a), .rdy_i(rdy_a), .ovr_o(ovr_a), .busy_o(busy_a)
    );

    serial_deframer #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_b (
        .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr), .stb_i(stb_b), .dat_i(dat),
        .lock_i(lock), .dat_o(dat_b), .perr_o(perr_b), .ferr_o(ferr_b),
        .vld_o(vld_b), .rdy_i(rdy_b), .ovr_o(ovr_b), .busy_o(busy_b)
    );

    // Frame-level model: the stimulus announces each expected push; the model
    // applies FWFT pop/push/overrun rules on the clock edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || clr) begin
            qa.delete();
            qb.delete();
            ovr_ma <= 1'b0;
            ovr_mb <= 1'b0;
        end else begin
            if (qa.size() != 0 && rdy_a) void'(qa.pop_front());
            if (push_a) begin
                if (qa.size() < 4) qa.push_back(pw_a);
                else ovr_ma <= 1'b1;
            end
            if (qb.size() != 0 && rdy_b) void'(qb.pop_front());
            if (push_b) begin
                if (qb.size() < 4) qb.push_back(pw_b);
                else ovr_mb <= 1'b1;
            end
        end
    end

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0b want %0b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %02h want %02h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_bit(input int u, input logic b);
        dat = b;
        if (u == 0) stb_a = 1'b1;
        else stb_b = 1'b1;
        tick();
        stb_a = 1'b0;
        stb_b = 1'b0;
        tick();
        tick();
    endtask

    task automatic send_frame(input int u, input logic [7:0] d, input logic pbit,
                              input logic stopb, input logic rdy_pulse);
        send_bit(u, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(u, d[i]);
        if (u == 1) send_bit(u, pbit);
        if (u == 0) begin
            pw_a.w  = d;
            pw_a.pe = 1'b0;
            pw_a.fe = ~stopb;
            push_a  = 1'b1;
            stb_a   = 1'b1;
            if (rdy_pulse) rdy_a = 1'b1;
        end else begin
            pw_b.w  = d;
            pw_b.pe = (pbit != ^d);
            pw_b.fe = ~stopb;
            push_b  = 1'b1;
            stb_b   = 1'b1;
            if (rdy_pulse) rdy_b = 1'b1;
        end
        dat = stopb;
        tick();
        push_a = 1'b0;
        push_b = 1'b0;
        stb_a  = 1'b0;
        stb_b  = 1'b0;
        if (rdy_pulse) begin
            rdy_a = 1'b0;
            rdy_b = 1'b0;
        end
        tick();
        tick();
    endtask

    task automatic pop_one(input int u);
        if (u == 0) rdy_a = 1'b1;
        else rdy_b = 1'b1;
        tick();
        rdy_a = 1'b0;
        rdy_b = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout at %0t", $time);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; clr = 1'b0; dat = 1'b1; lock = 1'b1;
        stb_a = 1'b0; stb_b = 1'b0; rdy_a = 1'b0; rdy_b = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (rst_n) begin
                    chk1("model_vld_a", vld_a, qa.size() != 0);
                    if (qa.size() != 0) begin
                        chk8("model_dat_a", dat_a, qa[0].w);
                        chk1("model_perr_a", perr_a, qa[0].pe);
                        chk1("model_ferr_a", ferr_a, qa[0].fe);
                    end
                    chk1("model_ovr_a", ovr_a, ovr_ma);
                    chk1("model_vld_b", vld_b, qb.size() != 0);
                    if (qb.size() != 0) begin
                        chk8("model_dat_b", dat_b, qb[0].w);
                        chk1("model_perr_b", perr_b, qb[0].pe);
                        chk1("model_ferr_b", ferr_b, qb[0].fe);
                    end
                    chk1("model_ovr_b", ovr_b, ovr_mb);
                end
            end
        join_none

        #23 rst_n = 1'b1;
        tick();
        chk1("rst_vld_a", vld_a, 1'b0);
        chk1("rst_ovr_a", ovr_a, 1'b0);
        chk1("rst_busy_a", busy_a, 1'b0);
        chk8("rst_dat_a", dat_a, 8'h00);
        chk1("rst_vld_b", vld_b, 1'b0);
        chk1("rst_busy_b", busy_b, 1'b0);

        // 8N1 frame 0xA5
        for (int i = 0; i < 3; i++) send_bit(0, 1'b1);
        send_frame(0, 8'hA5, 1'b0, 1'b1, 1'b0);
        chk1("t1_vld", vld_a, 1'b1);
        chk8("t1_dat", dat_a, 8'hA5);
        chk1("t1_perr", perr_a, 1'b0);
        chk1("t1_ferr", ferr_a, 1'b0);
        chk1("t1_busy", busy_a, 1'b0);
        pop_one(0);
        chk1("t1_vld_after_pop", vld_a, 1'b0);

        // even parity, data 0x03
        send_frame(1, 8'h03, 1'b1, 1'b1, 1'b0);
        chk8("t2_dat_bad", dat_b, 8'h03);
        chk1("t2_perr_bad", perr_b, 1'b1);
        pop_one(1);
        send_frame(1, 8'h03, 1'b0, 1'b1, 1'b0);
        chk8("t2_dat_good", dat_b, 8'h03);
        chk1("t2_perr_good", perr_b, 1'b0);
        pop_one(1);

        // overrun with five frames, then clear
        for (int k = 1; k <= 5; k++) send_frame(0, 8'(k), 1'b0, 1'b1, 1'b0);
        chk1("t4_ovr", ovr_a, 1'b1);
        chk1("t4_vld", vld_a, 1'b1);
        chk8("t4_head", dat_a, 8'h01);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk1("t4_clr_vld", vld_a, 1'b0);
        chk1("t4_clr_ovr", ovr_a, 1'b0);

        // push and pop on the same edge while full
        for (int k = 1; k <= 4; k++) send_frame(0, 8'(k), 1'b0, 1'b1, 1'b0);
        send_frame(0, 8'h05, 1'b0, 1'b1, 1'b1);
        chk1("t4_full_pushpop_ovr", ovr_a, 1'b0);
        for (int k = 2; k <= 5; k++) begin
            chk8("t4_drain", dat_a, 8'(k));
            pop_one(0);
        end
        chk1("t4_drained", vld_a, 1'b0);

        // framing error followed by a long break
        send_frame(0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk1("t3_ferr", ferr_a, 1'b1);
        chk8("t3_dat", dat_a, 8'h00);
        chk1("t3_busy_hunt", busy_a, 1'b1);
        for (int i = 0; i < 20; i++) send_bit(0, 1'b0);
        chk1("t3_busy_break", busy_a, 1'b1);
        send_bit(0, 1'b1);
        chk1("t3_busy_idle", busy_a, 1'b0);
        pop_one(0);
        chk1("t3_one_word", vld_a, 1'b0);
        send_frame(0, 8'h3C, 1'b0, 1'b1, 1'b0);
        chk8("t3_next", dat_a, 8'h3C);
        chk1("t3_next_ferr", ferr_a, 1'b0);
        pop_one(0);

        // lock loss mid-frame
        send_bit(0, 1'b0);
        send_bit(0, 1'b0);
        send_bit(0, 1'b1);
        send_bit(0, 1'b0);
        send_bit(0, 1'b1);
        chk1("t5_busy_before", busy_a, 1'b1);
        lock = 1'b0;
        tick();
        chk1("t5_busy_abort", busy_a, 1'b0);
        chk1("t5_no_push", vld_a, 1'b0);
        lock = 1'b1;
        tick();
        send_frame(0, 8'h5A, 1'b0, 1'b1, 1'b0);
        chk8("t5_relock", dat_a, 8'h5A);
        pop_one(0);

        // asynchronous reset mid-frame with a word queued
        send_frame(0, 8'h77, 1'b0, 1'b1, 1'b0);
        send_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(0, 1'b0);
        chk1("t6_busy_pre", busy_a, 1'b1);
        chk1("t6_vld_pre", vld_a, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk1("t6_vld_rst", vld_a, 1'b0);
        chk1("t6_busy_rst", busy_a, 1'b0);
        chk8("t6_dat_rst", dat_a, 8'h00);
        chk1("t6_ferr_rst", ferr_a, 1'b0);
        #3 rst_n = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) send_bit(0, 1'b1);
        chk1("t6_ignored_vld", vld_a, 1'b0);
        chk1("t6_ignored_busy", busy_a, 1'b0);
        send_frame(0, 8'h81, 1'b0, 1'b1, 1'b0);
        chk8("t6_after", dat_a, 8'h81);
        pop_one(0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
